// File: rtl/uart_pkg.sv
// Shared types and constants for the arbitrated UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int BAUD_DIV_DEFAULT = 414;
    localparam int DATA_BITS        = 8;
    localparam int FRAME_BITS       = 10;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..BAUD_DIV-1 and flags the last cycle of each period.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic CLKIN,
    input  logic RESETN,
    input  logic clr,
    output logic tick
);

    localparam logic [8:0] LAST = 9'(BAUD_DIV - 1);

    logic [8:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 9'd1;
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Two-requester round-robin arbiter feeding a single 8N1 UART transmitter.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | line high, arbiter offers ready, handshake loads byte
//   ST_START | start bit (low) for one bit period
//   ST_DATA  | captured byte shifted out LSB first, 8 bit periods
//   ST_STOP  | stop bit (high) for one bit period, then back to idle
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       CLKIN,
    input  logic       RESETN,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       TX,
    output logic       busy,
    output logic       grant
);

    tx_state_t  state, state_nxt;
    logic [7:0] byte_q;
    logic [2:0] bit_idx;
    logic       grant_q;
    logic       last_q;
    logic       sel;
    logic       hs;
    logic       tick;

    // Contention goes to whoever was not served last; otherwise the lone requester wins.
    assign sel   = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    assign hs    = (state == ST_IDLE) && (req0_valid || req1_valid);
    assign grant = grant_q;

    uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .CLKIN  (CLKIN),
        .RESETN (RESETN),
        .clr    (state == ST_IDLE),
        .tick   (tick)
    );

    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (hs)   state_nxt = ST_START;
            ST_START: if (tick) state_nxt = ST_DATA;
            ST_DATA:  if (tick && (bit_idx == 3'(DATA_BITS - 1))) state_nxt = ST_STOP;
            ST_STOP:  if (tick) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // last_q resets to 1 so requester 0 wins the first contended request.
    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            byte_q  <= '0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            bit_idx <= '0;
        end else begin
            if (hs) begin
                byte_q  <= sel ? req1_data : req0_data;
                grant_q <= sel;
                last_q  <= sel;
            end
            if ((state == ST_DATA) && tick) begin
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    always_comb begin
        TX         = 1'b1;
        busy       = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                req0_ready = RESETN && req0_valid && !sel;
                req1_ready = RESETN && req1_valid && sel;
            end
            ST_START: begin
                TX   = 1'b0;
                busy = 1'b1;
            end
            ST_DATA: begin
                TX   = byte_q[bit_idx];
                busy = 1'b1;
            end
            ST_STOP: begin
                busy = 1'b1;
            end
            default: begin
                TX = 1'b1;
            end
        endcase
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter: BAUD_DIV, default 414, clock cycles per serial bit period (legal range 2..511).
REQ-002 SHALL have port: CLKIN  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: RESETN  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: req0_valid  input  1  requester 0 has a byte to send.
REQ-005 SHALL have port: req0_data  input  8  requester 0 byte.
REQ-006 SHALL have port: req0_ready  output  1  requester 0 byte accepted this cycle.
REQ-007 SHALL have ports req1_valid/req1_data/req1_ready, identical to requester 0.
REQ-008 SHALL have port: TX  output  1  serial line, 8N1, idle high.
REQ-009 SHALL have port: busy  output  1  frame in progress (any state other than IDLE).
REQ-010 SHALL have port: grant  output  1  index of requester whose byte is on TX; holds last value when idle.

Function
REQ-011 SHALL implement FSM IDLE -> START -> DATA -> STOP -> IDLE.
REQ-012 Each of START, STOP and each DATA bit SHALL last exactly BAUD_DIV cycles, timed by a 9-bit bit-period counter counting 0..BAUD_DIV-1.
REQ-013 IDLE: TX=1; reqN_ready is combinational = (state==IDLE) && reqN_valid && (N selected by arbiter); at most one ready high per cycle.
REQ-014 Arbitration SHALL be round-robin: if only one valid, that one wins; if both valid, the requester not served last wins.
REQ-015 On handshake (valid && ready): byte and grant SHALL be captured, next state START, bit-period counter cleared.
REQ-016 START: TX=0, beginning the cycle after the handshake (latency 1).
REQ-017 DATA: TX = captured bit i, LSB first, i=0..7; 3-bit index advances at each period end; after bit 7 go to STOP.
REQ-018 STOP: TX=1; at period end go to IDLE.
REQ-019 Full frame SHALL occupy 10*BAUD_DIV cycles; back-to-back frames SHALL be separated by exactly one IDLE cycle (the handshake cycle).
REQ-020 Inputs SHALL be ignored outside IDLE; changes to reqN_data or reqN_valid after handshake SHALL NOT affect the current frame.
REQ-021 Requesters SHALL hold valid and data stable until ready; a valid dropped before ready forfeits nothing and leaves the round-robin pointer unchanged.
REQ-022 Round-robin pointer SHALL update only on a handshake.
REQ-023 busy SHALL be 1 from the cycle after handshake through the last STOP cycle, 0 otherwise.

Reset
REQ-024 RESETN low SHALL immediately force: state=IDLE, TX=1, busy=0, both ready=0, counters=0, bit index=0, captured byte=0, grant=0, pointer set so requester 0 wins a simultaneous first request.
REQ-025 Reset asserted mid-frame SHALL abort the frame with TX returning high at once; no partial frame resumes after release.
REQ-026 First handshake SHALL be possible on the first rising edge with RESETN high.

Structure
REQ-027 Shared package uart_pkg SHALL hold the FSM state enum, BAUD_DIV_DEFAULT=414, DATA_BITS=8, FRAME_BITS=10.
REQ-028 Bit-period timing SHALL be a sub-module uart_baud_tick (counter, synchronous clear input, one-cycle tick at count BAUD_DIV-1); arbitration and FSM stay in uart_tx_arb.

Verification (benches use BAUD_DIV=4)
REQ-029 Single request: req0 valid, data 0xA5 -> req0_ready for 1 cycle; TX = 0,1,0,1,0,0,1,0,1,1 (4 cycles each, start to stop), 40 cycles; busy high 40 cycles; grant=0.
REQ-030 Simultaneous: both valid (0x11, 0x22) held -> req0 served first, then req1 after exactly one IDLE cycle; grant 0 then 1.
REQ-031 Fairness: both valid continuously for 4 frames -> grant sequence 0,1,0,1; each ready pulses twice.
REQ-032 Data change: req1 sends 0x0F, data changed to 0xF0 during DATA -> TX still carries 0x0F.
REQ-033 Reset mid-frame: RESETN low during DATA bit 3 -> TX=1, busy=0 asynchronously; after release, pending req0 0x55 -> complete fresh frame.
REQ-034 Boundary: BAUD_DIV=2, byte 0xFF -> frame exactly 20 cycles, TX low only during START.
